// File: rtl/tqvp_text_pkg.sv
// Shared constants and types for the TinyQV text buffer peripheral.
package tqvp_text_pkg;

  // Register map
  localparam logic [5:0] REG_CHAR   = 6'h00;
  localparam logic [5:0] REG_CURSOR = 6'h04;
  localparam logic [5:0] REG_CTRL   = 6'h08;

  // CTRL write bit positions
  localparam int CTRL_CLEAR_BIT = 0;
  localparam int CTRL_ACK_BIT   = 1;
  localparam int CTRL_IRQEN_BIT = 2;

  // STATUS read bit positions
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_PEND_BIT  = 1;
  localparam int STAT_IRQEN_BIT = 2;

  // Control characters recognised by the CHAR register
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Bus strobe encodings
  localparam logic [1:0] BUS_NONE = 2'b11;
  localparam logic [1:0] BUS_BYTE = 2'b00;

  // Clear engine states
  typedef enum logic {
    CLR_IDLE,
    CLR_CLEAR
  } clr_state_t;

  // Linear cell index of a (row, col) pair; 16 bits covers 255x255 screens
  function automatic logic [15:0] cellIndex(input logic [7:0] row,
                                            input logic [7:0] col,
                                            input int         cols);
    return 16'(row) * 16'(cols) + 16'(col);
  endfunction

endpackage

// File: rtl/tqvp_text_cursor.sv
// Hardware cursor: holds row/col and applies load, CR, LF and auto-advance.
// Emits a single-cycle wrap pulse when stepping past the last row.
module tqvp_text_cursor
  import tqvp_text_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_home,
  input  logic       i_load,
  input  logic [7:0] i_loadRow,
  input  logic [7:0] i_loadCol,
  input  logic       i_cr,
  input  logic       i_lf,
  input  logic       i_advance,
  output logic [7:0] o_row,
  output logic [7:0] o_col,
  output logic       o_wrap
);

  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

  logic [7:0] r_row;
  logic [7:0] r_col;
  logic [7:0] w_nextRow;
  logic [7:0] w_nextCol;
  logic       w_rowStep;

  // Next cursor position; a row step off the bottom wraps to row 0 and flags it
  always_comb begin
    w_nextRow = r_row;
    w_nextCol = r_col;
    w_rowStep = 1'b0;
    o_wrap    = 1'b0;
    if (i_home) begin
      w_nextRow = '0;
      w_nextCol = '0;
    end else if (i_load) begin
      w_nextRow = i_loadRow;
      w_nextCol = i_loadCol;
    end else if (i_lf) begin
      w_nextCol = '0;
      w_rowStep = 1'b1;
    end else if (i_cr) begin
      w_nextCol = '0;
    end else if (i_advance) begin
      if (r_col == LAST_COL) begin
        w_nextCol = '0;
        w_rowStep = 1'b1;
      end else begin
        w_nextCol = r_col + 8'd1;
      end
    end
    if (w_rowStep) begin
      if (r_row == LAST_ROW) begin
        w_nextRow = '0;
        o_wrap    = 1'b1;
      end else begin
        w_nextRow = r_row + 8'd1;
      end
    end
  end

  // Cursor registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      r_row <= w_nextRow;
      r_col <= w_nextCol;
    end
  end

  assign o_row = r_row;
  assign o_col = r_col;

endmodule

// File: rtl/tqvp_text_buffer.sv
// Character-cell text buffer for the VGA console on the TinyQV peripheral bus.
// CPU writes land at an auto-advancing cursor; a clear engine fills the screen
// with FILL_CHAR; a registered display port feeds the scan-out logic.
module tqvp_text_buffer
  import tqvp_text_pkg::*;
#(
  parameter int                COLS      = 16,
  parameter int                ROWS      = 6,
  parameter int                CHAR_W    = 7,
  parameter logic [CHAR_W-1:0] FILL_CHAR = 7'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        ui_in,
  output logic [7:0]        uo_out,
  input  logic [5:0]        address,
  input  logic [31:0]       data_in,
  input  logic [1:0]        data_write_n,
  input  logic [1:0]        data_read_n,
  output logic [31:0]       data_out,
  output logic              data_ready,
  output logic              user_interrupt,
  input  logic [7:0]        disp_col,
  input  logic [7:0]        disp_row,
  output logic [CHAR_W-1:0] disp_char
);

  localparam int                CELLS    = COLS * ROWS;
  localparam int                IDX_W    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CELLS - 1);

  logic [CHAR_W-1:0] r_mem [CELLS];
  logic [CHAR_W-1:0] r_dispChar;
  clr_state_t        r_clrState;
  logic [IDX_W-1:0]  r_clrIdx;
  logic              r_busy;
  logic              r_irqPending;
  logic              r_irqEn;

  logic [7:0]        w_row;
  logic [7:0]        w_col;
  logic              w_wrap;
  logic [IDX_W-1:0]  w_curIdx;
  logic [IDX_W-1:0]  w_dispIdx;
  logic              w_dispInRange;
  logic              w_wrEn;
  logic              w_rdEn;
  logic              w_charWr;
  logic              w_isCr;
  logic              w_isLf;
  logic              w_store;
  logic              w_cursorWr;
  logic              w_ctrlWr;
  logic              w_clrStart;
  logic              w_clrDone;
  logic              w_unused;

  assign w_unused = &{1'b0, ui_in, data_in[31:16]};

  assign w_wrEn   = (data_write_n != BUS_NONE);
  assign w_rdEn   = (data_read_n != BUS_NONE);
  assign w_isCr   = (data_in[7:0] == CHAR_CR);
  assign w_isLf   = (data_in[7:0] == CHAR_LF);
  assign w_charWr = w_wrEn && (address == REG_CHAR) && !r_busy;
  assign w_store  = w_charWr && !w_isCr && !w_isLf;
  assign w_ctrlWr = w_wrEn && (address == REG_CTRL);

  // Cursor loads need a half/word write with both fields on screen
  assign w_cursorWr = w_wrEn && (address == REG_CURSOR) && (data_write_n != BUS_BYTE)
                      && !r_busy && (data_in[7:0] < 8'(COLS)) && (data_in[15:8] < 8'(ROWS));

  assign w_clrStart = w_ctrlWr && data_in[CTRL_CLEAR_BIT] && !r_busy;
  assign w_clrDone  = (r_clrState == CLR_CLEAR) && (r_clrIdx == LAST_IDX);

  assign w_curIdx      = IDX_W'(cellIndex(w_row, w_col, COLS));
  assign w_dispIdx     = IDX_W'(cellIndex(disp_row, disp_col, COLS));
  assign w_dispInRange = (disp_col < 8'(COLS)) && (disp_row < 8'(ROWS));

  tqvp_text_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_home    (w_clrDone),
    .i_load    (w_cursorWr),
    .i_loadRow (data_in[15:8]),
    .i_loadCol (data_in[7:0]),
    .i_cr      (w_charWr && w_isCr),
    .i_lf      (w_charWr && w_isLf),
    .i_advance (w_store),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_wrap    (w_wrap)
  );

  // Single write port: the clear engine owns it while busy, otherwise the CPU
  always_ff @(posedge clk) begin
    if (r_clrState == CLR_CLEAR) begin
      r_mem[r_clrIdx] <= FILL_CHAR;
    end else if (w_store) begin
      r_mem[w_curIdx] <= data_in[CHAR_W-1:0];
    end
  end

  // Display read port, one cycle latency, zero outside the screen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dispChar <= '0;
    end else if (w_dispInRange) begin
      r_dispChar <= r_mem[w_dispIdx];
    end else begin
      r_dispChar <= '0;
    end
  end

  // Clear engine: walks every cell once, then homes the cursor
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clrState <= CLR_IDLE;
      r_clrIdx   <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_clrState)
        CLR_IDLE: begin
          if (w_clrStart) begin
            r_clrState <= CLR_CLEAR;
            r_clrIdx   <= '0;
            r_busy     <= 1'b1;
          end
        end
        CLR_CLEAR: begin
          if (r_clrIdx == LAST_IDX) begin
            r_clrState <= CLR_IDLE;
            r_clrIdx   <= '0;
            r_busy     <= 1'b0;
          end else begin
            r_clrIdx <= r_clrIdx + IDX_W'(1);
          end
        end
        default: begin
          r_clrState <= CLR_IDLE;
          r_clrIdx   <= '0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Interrupt state; a wrap in the same cycle as an acknowledge keeps the flag set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_irqPending <= 1'b0;
      r_irqEn      <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_irqPending <= 1'b1;
      end else if (w_ctrlWr && data_in[CTRL_ACK_BIT]) begin
        r_irqPending <= 1'b0;
      end
      if (w_ctrlWr) begin
        r_irqEn <= data_in[CTRL_IRQEN_BIT];
      end
    end
  end

  // Register read mux; reads always complete in the cycle they are issued
  always_comb begin
    data_out = '0;
    if (w_rdEn) begin
      case (address)
        REG_CHAR:   data_out = 32'(r_mem[w_curIdx]);
        REG_CURSOR: data_out = {16'h0, w_row, w_col};
        REG_CTRL: begin
          data_out[STAT_BUSY_BIT]  = r_busy;
          data_out[STAT_PEND_BIT]  = r_irqPending;
          data_out[STAT_IRQEN_BIT] = r_irqEn;
        end
        default: data_out = '0;
      endcase
    end
  end

  assign data_ready     = 1'b1;
  assign uo_out         = {r_busy, r_irqPending, 6'b0};
  assign user_interrupt = r_irqPending & r_irqEn;
  assign disp_char      = r_dispChar;

endmodule

// File: tb/tb_tqvp_text_buffer.sv
// Directed self-checking bench for tqvp_text_buffer (16x6 cells, 7-bit chars).
module tb_tqvp_text_buffer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;
  logic [7:0]  disp_col;
  logic [7:0]  disp_row;
  logic [6:0]  disp_char;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [5:0] A_CHAR   = 6'h00;
  localparam logic [5:0] A_CURSOR = 6'h04;
  localparam logic [5:0] A_CTRL   = 6'h08;
  localparam logic [1:0] WR_BYTE  = 2'b00;
  localparam logic [1:0] WR_HALF  = 2'b01;
  localparam logic [1:0] WR_WORD  = 2'b10;

  tqvp_text_buffer #(
    .COLS      (16),
    .ROWS      (6),
    .CHAR_W    (7),
    .FILL_CHAR (7'h20)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt),
    .disp_col       (disp_col),
    .disp_row       (disp_row),
    .disp_char      (disp_char)
  );

  // 64 MHz-ish clock
  initial clk = 1'b0;
  always #8 clk = ~clk;

  // Count one comparison and report it if it disagrees
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One bus write, presented for exactly one rising edge
  task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data,
                               input logic [1:0] size);
    @(negedge clk);
    address      = addr;
    data_in      = data;
    data_write_n = size;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  // Combinational register read taken in the low clock phase
  task automatic readRegister(input logic [5:0] addr, output logic [31:0] value);
    address     = addr;
    data_read_n = 2'b10;
    #1;
    value       = data_out;
    data_read_n = 2'b11;
  endtask

  // Drive display coordinates and sample one cycle later
  task automatic dispRead(input logic [7:0] row, input logic [7:0] col,
                          output logic [31:0] value);
    @(negedge clk);
    disp_row = row;
    disp_col = col;
    @(negedge clk);
    value = 32'(disp_char);
  endtask

  // Wait for busy to drop, returning the number of busy cycles observed
  task automatic waitIdle(output int cycles);
    logic [31:0] st;
    cycles = 0;
    readRegister(A_CTRL, st);
    while (st[0] && cycles < 300) begin
      cycles++;
      @(negedge clk);
      readRegister(A_CTRL, st);
    end
  endtask

  initial begin
    logic [31:0] v;
    int          n;

    rst_n        = 1'b0;
    ui_in        = 8'h00;
    address      = 6'h00;
    data_in      = 32'h0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    disp_col     = 8'h00;
    disp_row     = 8'h00;

    repeat (3) @(negedge clk);
    checkOutput("reset disp_char", 32'(disp_char), 32'h0);
    checkOutput("reset uo_out", 32'(uo_out), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset values");
    readRegister(A_CURSOR, v); checkOutput("reset CURSOR", v, 32'h0);
    readRegister(A_CTRL, v);   checkOutput("reset STATUS", v, 32'h0);
    checkOutput("reset uo_out run", 32'(uo_out), 32'h0);
    checkOutput("reset irq", 32'(user_interrupt), 32'h0);
    checkOutput("data_ready", 32'(data_ready), 32'h1);

    $display("[TB] clear engine timing");
    applyStimulus(A_CTRL, 32'h1, WR_WORD);
    checkOutput("uo_out busy", 32'(uo_out), 32'h80);
    waitIdle(n);
    checkOutput("clear cycles", 32'(n), 32'd96);
    readRegister(A_CTRL, v);   checkOutput("post-clear STATUS", v, 32'h0);
    readRegister(A_CURSOR, v); checkOutput("post-clear CURSOR", v, 32'h0);
    dispRead(8'd5, 8'd15, v);  checkOutput("disp(5,15)", v, 32'h20);
    dispRead(8'd0, 8'd0, v);   checkOutput("disp(0,0)", v, 32'h20);
    dispRead(8'd6, 8'd0, v);   checkOutput("disp row oob", v, 32'h0);
    dispRead(8'd0, 8'd16, v);  checkOutput("disp col oob", v, 32'h0);

    $display("[TB] column wrap");
    applyStimulus(A_CURSOR, 32'h0000010F, WR_WORD);
    applyStimulus(A_CHAR, 32'h41, WR_BYTE);
    dispRead(8'd1, 8'd15, v);  checkOutput("disp(1,15) A", v, 32'h41);
    readRegister(A_CURSOR, v); checkOutput("CURSOR after A", v, 32'h00000200);
    readRegister(A_CHAR, v);   checkOutput("CHAR read (2,0)", v, 32'h20);

    $display("[TB] LF and CR");
    applyStimulus(A_CURSOR, 32'h00000203, WR_HALF);
    applyStimulus(A_CHAR, 32'h0A, WR_BYTE);
    readRegister(A_CURSOR, v); checkOutput("CURSOR after LF", v, 32'h00000300);
    dispRead(8'd2, 8'd3, v);   checkOutput("cell(2,3) kept", v, 32'h20);
    applyStimulus(A_CURSOR, 32'h00000305, WR_HALF);
    applyStimulus(A_CHAR, 32'h0D, WR_BYTE);
    readRegister(A_CURSOR, v); checkOutput("CURSOR after CR", v, 32'h00000300);

    $display("[TB] screen wrap interrupt");
    applyStimulus(A_CTRL, 32'h4, WR_WORD);
    applyStimulus(A_CURSOR, 32'h0000050F, WR_WORD);
    applyStimulus(A_CHAR, 32'h5A, WR_BYTE);
    readRegister(A_CURSOR, v); checkOutput("CURSOR after wrap", v, 32'h0);
    readRegister(A_CTRL, v);   checkOutput("STATUS after wrap", v, 32'h6);
    checkOutput("irq after wrap", 32'(user_interrupt), 32'h1);
    checkOutput("uo_out irq", 32'(uo_out), 32'h40);
    dispRead(8'd5, 8'd15, v);  checkOutput("disp(5,15) Z", v, 32'h5A);
    applyStimulus(A_CTRL, 32'h6, WR_WORD);
    readRegister(A_CTRL, v);   checkOutput("STATUS after ack", v, 32'h4);
    checkOutput("irq after ack", 32'(user_interrupt), 32'h0);

    $display("[TB] ignored cursor writes");
    applyStimulus(A_CURSOR, 32'h00000102, WR_BYTE);
    readRegister(A_CURSOR, v); checkOutput("byte CURSOR ignored", v, 32'h0);
    applyStimulus(A_CURSOR, 32'h00000600, WR_WORD);
    readRegister(A_CURSOR, v); checkOutput("row oob ignored", v, 32'h0);

    $display("[TB] writes during clear");
    applyStimulus(A_CTRL, 32'h1, WR_WORD);
    applyStimulus(A_CURSOR, 32'h00000203, WR_WORD);
    readRegister(A_CURSOR, v); checkOutput("busy CURSOR dropped", v, 32'h0);
    applyStimulus(A_CHAR, 32'h51, WR_BYTE);
    readRegister(A_CURSOR, v); checkOutput("busy CHAR no advance", v, 32'h0);
    readRegister(A_CHAR, v);   checkOutput("busy CHAR read", v, 32'h20);
    applyStimulus(A_CTRL, 32'h4, WR_WORD);
    readRegister(A_CTRL, v);   checkOutput("busy STATUS irq_en", v, 32'h5);
    waitIdle(n);
    checkOutput("clear finished", 32'(n < 300), 32'h1);
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 16; c++) begin
        dispRead(8'(r), 8'(c), v);
        checkOutput($sformatf("cleared(%0d,%0d)", r, c), v, 32'h20);
      end
    end
    readRegister(A_CURSOR, v); checkOutput("CURSOR after clear2", v, 32'h0);
    readRegister(A_CTRL, v);   checkOutput("STATUS after clear2", v, 32'h4);
    applyStimulus(A_CURSOR, 32'h00000010, WR_WORD);
    readRegister(A_CURSOR, v); checkOutput("col 16 ignored", v, 32'h0);

    $display("[TB] reset during clear");
    applyStimulus(A_CTRL, 32'h1, WR_WORD);
    repeat (5) @(negedge clk);
    readRegister(A_CTRL, v);   checkOutput("mid-clear busy", v, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    readRegister(A_CTRL, v);   checkOutput("STATUS after reset", v, 32'h0);
    checkOutput("uo_out after reset", 32'(uo_out), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
